// File: rtl/lighting_pkg.sv
// Shared lamp-drive types: FSM state encoding used by the controller core, the driver and the bench.
package lighting_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } lamp_state_t;

  // True when no ramp is in progress.
  function automatic logic is_settled(input lamp_state_t s);
    return (s == OFF) || (s == ON);
  endfunction

endpackage

// File: rtl/lamp_pwm_driver_pwm_gen.sv
// PWM generator: free-running period counter, duty latched at period wrap, registered output.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty_active;
  logic                wrap;

  assign wrap = (cnt == CNT_LAST);

  // Period is 2**PWM_BITS-1 clocks so that a full-scale duty gives a constant high output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      duty_active <= '0;
      pwm_out     <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + PWM_BITS'(1);
      pwm_out <= (cnt < duty_active);
      if (wrap) begin
        duty_active <= duty;
      end
    end
  end

endmodule

// File: rtl/lamp_pwm_driver.sv
// Lamp drive: soft-start/soft-stop duty ramp FSM with full-on override, feeding a PWM generator.
module lamp_pwm_driver
  import lighting_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lamp_on,
  input  logic                force_full,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          state_o,
  output logic                at_target
);

  localparam int unsigned         TIMER_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]  STEP_LAST = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] MAX_DUTY  = '1;

  lamp_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                at_target_q;
  logic                step;

  assign step = (timer_q == STEP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OFF;
      duty_q      <= '0;
      timer_q     <= '0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      timer_q     <= timer_d;
      at_target_q <= is_settled(state_d);
    end
  end

  // A level change always wins over a coincident step; the step is dropped and the timer restarts.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    timer_d = timer_q;
    if (force_full && lamp_on) begin
      state_d = ON;
      duty_d  = MAX_DUTY;
    end else begin
      case (state_q)
        OFF: begin
          if (lamp_on) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (!lamp_on) begin
            state_d = RAMP_DOWN;
          end else if (step) begin
            if (duty_q != MAX_DUTY) duty_d = duty_q + PWM_BITS'(1);
            if (duty_d == MAX_DUTY) state_d = ON;
          end
        end
        ON: begin
          if (!lamp_on) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (lamp_on) begin
            state_d = RAMP_UP;
          end else if (step) begin
            if (duty_q != '0) duty_d = duty_q - PWM_BITS'(1);
            if (duty_d == '0) state_d = OFF;
          end
        end
        default: state_d = OFF;
      endcase
    end

    if ((state_d != state_q) || is_settled(state_q) || step) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk    (clk),
    .rst    (rst),
    .duty   (duty_q),
    .pwm_out(pwm_out)
  );

  assign duty      = duty_q;
  assign state_o   = state_q;
  assign at_target = at_target_q;

endmodule

// File: tb/tb_lamp_pwm_driver.sv
// Scoreboard bench for lamp_pwm_driver: stimulus pushes model predictions, a monitor pops and compares.
module tb_lamp_pwm_driver;
  import lighting_pkg::*;

  localparam int PWM_BITS = 4;
  localparam int STEP     = 2;
  localparam int PERIOD   = (1 << PWM_BITS) - 1;
  localparam int MAXD     = PERIOD;

  logic                clk = 1'b0;
  logic                rst;
  logic                lamp_on;
  logic                force_full;
  logic                pwm_out;
  logic [PWM_BITS-1:0] duty;
  logic [1:0]          state_o;
  logic                at_target;

  lamp_pwm_driver #(
    .PWM_BITS   (PWM_BITS),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lamp_on   (lamp_on),
    .force_full(force_full),
    .pwm_out   (pwm_out),
    .duty      (duty),
    .state_o   (state_o),
    .at_target (at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int state;
    int duty;
    bit at;
    bit pwm;
    bit is_rst;
    bit win_end;
    int win_hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model, kept as plain integers: lamp level, elapsed ramp clocks and a period-based PWM.
  int m_state, m_duty, m_elapsed, m_cnt, m_active;
  bit m_pwm;

  task automatic model_step(input bit r, input bit lo, input bit ff);
    exp_t e;
    int   n_state, n_duty, n_elapsed;
    bit   ramping, stp;
    e.is_rst  = r;
    e.win_end = 0;
    e.win_hi  = 0;
    if (r) begin
      m_state = 0; m_duty = 0; m_elapsed = 0; m_cnt = 0; m_active = 0; m_pwm = 0;
    end else begin
      e.win_end = (m_cnt == PERIOD - 1);
      e.win_hi  = m_active;
      m_pwm     = (m_cnt < m_active);
      if (m_cnt == PERIOD - 1) m_active = m_duty;
      m_cnt     = (m_cnt + 1) % PERIOD;

      ramping = (m_state == 1) || (m_state == 3);
      stp     = ramping && (((m_elapsed + 1) % STEP) == 0);
      n_state = m_state;
      n_duty  = m_duty;
      if (ff && lo) begin
        n_state = 2; n_duty = MAXD;
      end else if (m_state == 0 && lo)  n_state = 1;
      else if (m_state == 2 && !lo)     n_state = 3;
      else if (m_state == 1 && !lo)     n_state = 3;
      else if (m_state == 3 && lo)      n_state = 1;
      else if (stp && m_state == 1) begin
        n_duty = (m_duty + 1 > MAXD) ? MAXD : m_duty + 1;
        if (n_duty == MAXD) n_state = 2;
      end else if (stp && m_state == 3) begin
        n_duty = (m_duty - 1 < 0) ? 0 : m_duty - 1;
        if (n_duty == 0) n_state = 0;
      end
      n_elapsed = (n_state != m_state) ? 0 : (ramping ? m_elapsed + 1 : 0);
      m_state = n_state; m_duty = n_duty; m_elapsed = n_elapsed;
    end
    e.state = m_state;
    e.duty  = m_duty;
    e.at    = (m_state == 0) || (m_state == 2);
    e.pwm   = m_pwm;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit r, input bit lo, input bit ff);
    rst = r; lamp_on = lo; force_full = ff;
    model_step(r, lo, ff);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input bit lo, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, lo, 1'b0);
  endtask

  task automatic until_duty(input bit lo, input int target);
    int budget = 200;
    while (m_duty != target && budget > 0) begin
      cycle(1'b0, lo, 1'b0);
      budget--;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every clock presents a fresh output set, sampled on the falling edge.
  initial begin
    exp_t e;
    int   hi_cnt = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("queue_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("state_o", int'(state_o), e.state);
        check("duty", int'(duty), e.duty);
        check("at_target", int'(at_target), int'(e.at));
        check("pwm_out", int'(pwm_out), int'(e.pwm));
        if (e.is_rst) begin
          hi_cnt = 0;
        end else begin
          hi_cnt += int'(pwm_out);
          if (e.win_end) begin
            check("period_high_count", hi_cnt, e.win_hi);
            hi_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    int budget;
    bit lo;
    // Reset with random inputs.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 1'($urandom));
    // Full ramp up, then full ramp down.
    hold(1'b1, 50);
    hold(1'b0, 50);
    // Reverse mid ramp at duty 7.
    until_duty(1'b1, 7);
    hold(1'b0, 40);
    // Override at duty 3, then override ignored while lamp off.
    until_duty(1'b1, 3);
    cycle(1'b0, 1'b1, 1'b1);
    hold(1'b1, 5);
    hold(1'b0, 40);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1);
    // Reset mid ramp-down at duty 9, then ramp again from zero.
    until_duty(1'b1, MAXD);
    until_duty(1'b0, 9);
    cycle(1'b1, 1'b1, 1'b0);
    hold(1'b1, 20);
    // Randomized traffic.
    lo = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lo = ~lo;
      cycle(($urandom_range(0, 599) == 0), lo, ($urandom_range(0, 79) == 0));
    end
    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
